oam_dma: RTL and testbench

OAM DMA controller: the bus initiator that copies one 256-byte page of CPU address space into PPU object memory. It snoops CPU writes to the DMA trigger register, halts the CPU, then alternates read/write cycles on the system data bus. It reads from responders such as work RAM and writes each byte to the OAM data port. It sits beside the CPU and owns the bus only while a transfer is active.

---
 rtl/oam_dma.sv | 103 ++++++++++
 tb/tb_oam_dma.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA controller: copies one 256-byte CPU page into PPU object memory
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpuAddr,
    input  logic [7:0]  cpuData,
    input  logic        cpuWrite,
    output logic        cpuHalt,
    output logic        busOwn,
    output logic [15:0] busAddr,
    output logic        busWrite,
    output logic [7:0]  busDataOut,
    input  logic [7:0]  busDataIn,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        parity;
    logic [7:0]  page;
    logic [7:0]  index;
    logic [7:0]  data;
    logic        done_q;
    logic        trigger;

    assign trigger = cpuWrite && (cpuAddr == TRIGGER_ADDR);

    // parity free-runs so a transfer can line its first read up with the CPU's even cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            index  <= 8'h00;
            data   <= 8'h00;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            parity <= ~parity;
            done_q <= (state == S_WRITE) && (index == 8'hFF);
            if (state == S_IDLE && trigger) begin
                page  <= cpuData;
                index <= 8'h00;
            end
            if (state == S_READ) begin
                data <= busDataIn;
            end
            if (state == S_WRITE) begin
                index <= index + 8'h01;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (trigger) state_nx = S_HALT;
            S_HALT:  state_nx = parity ? S_ALIGN : S_READ;
            S_ALIGN: state_nx = S_READ;
            S_READ:  state_nx = S_WRITE;
            S_WRITE: state_nx = (index == 8'hFF) ? S_IDLE : S_READ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cpuHalt    = 1'b0;
        busOwn     = 1'b0;
        busAddr    = 16'h0000;
        busWrite   = 1'b0;
        busDataOut = 8'h00;
        case (state)
            S_HALT, S_ALIGN: cpuHalt = 1'b1;
            S_READ: begin
                cpuHalt = 1'b1;
                busOwn  = 1'b1;
                busAddr = {page, index};
            end
            S_WRITE: begin
                cpuHalt    = 1'b1;
                busOwn     = 1'b1;
                busAddr    = OAM_DATA_ADDR;
                busWrite   = 1'b1;
                busDataOut = data;
            end
            default: ;
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma against a cycle-offset transfer model
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] cpuAddr;
    logic [7:0]  cpuData;
    logic        cpuWrite;
    logic        cpuHalt;
    logic        busOwn;
    logic [15:0] busAddr;
    logic        busWrite;
    logic [7:0]  busDataOut;
    logic [7:0]  busDataIn;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [7:0] mem [0:65535];

    oam_dma dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpuAddr    (cpuAddr),
        .cpuData    (cpuData),
        .cpuWrite   (cpuWrite),
        .cpuHalt    (cpuHalt),
        .busOwn     (busOwn),
        .busAddr    (busAddr),
        .busWrite   (busWrite),
        .busDataOut (busDataOut),
        .busDataIn  (busDataIn),
        .done       (done)
    );

    always #5 clock = ~clock;

    assign busDataIn = mem[busAddr];

    // cycles since the last reset edge; its LSB is the parity the DUT should see
    always @(posedge clock) cyc <= reset_n ? cyc + 1 : 0;

    task automatic align_to(input int p);
        for (int n = 0; n < 2; n++)
            if (((cyc + 1) & 1) != p) @(negedge clock);
    endtask

    // Trigger a transfer now (caller is at a negedge) and check every cycle until done.
    // retrig_idx/abort_idx >= 0 inject a retrigger after WRITE of that index / reset in its READ.
    task automatic run_xfer(input logic [7:0] pg, input int retrig_idx, input int abort_idx);
        int p, rs, last, j, retrig_at, abort_at;
        bit own, rd, wr;
        logic [15:0] a;
        logic [7:0] d;
        logic [27:0] e, o;
        cpuAddr  = 16'h4014;
        cpuData  = pg;
        cpuWrite = 1'b1;
        p    = (cyc + 1) & 1;
        rs   = 2 + p;
        last = rs + 512;
        retrig_at = (retrig_idx < 0) ? -1 : rs + 2 * retrig_idx + 1;
        abort_at  = (abort_idx < 0) ? -1 : rs + 2 * abort_idx;
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            own = (k >= rs) && (k < rs + 512);
            j   = own ? (k - rs) / 2 : 0;
            rd  = own && (((k - rs) % 2) == 0);
            wr  = own && !rd;
            a   = !own ? 16'h0000 : (rd ? {pg, j[7:0]} : 16'h2004);
            d   = wr ? mem[{pg, j[7:0]}] : 8'h00;
            e   = {(k < rs + 512), own, a, wr, d, (k == last)};
            o   = {cpuHalt, busOwn, busAddr, busWrite, (rd ? 8'h00 : busDataOut), done};
            total_cnt++;
            if (o !== e)
                $display("FAIL xfer page=%02h align=%0d cycle=%0d: got halt/own/addr/wr/data/done=%h want %h",
                         pg, p, k, o, e);
            else
                pass_cnt++;
            cpuWrite = 1'b0;
            cpuAddr  = 16'($urandom);
            cpuData  = 8'($urandom);
            if (k == retrig_at) begin
                cpuAddr  = 16'h4014;
                cpuData  = ~pg;
                cpuWrite = 1'b1;
            end
            if (k == abort_at) begin
                reset_n = 1'b0;
                @(negedge clock);
                o = {cpuHalt, busOwn, busAddr, busWrite, busDataOut, done};
                total_cnt++;
                if (o !== 28'h0)
                    $display("FAIL abort_outputs: got %h want 0", o);
                else
                    pass_cnt++;
                reset_n = 1'b1;
                for (int m = 0; m < 3; m++) begin
                    @(negedge clock);
                    o = {cpuHalt, busOwn, busAddr, busWrite, busDataOut, done};
                    total_cnt++;
                    if (o !== 28'h0)
                        $display("FAIL abort_idle cycle=%0d: got %h want 0", m, o);
                    else
                        pass_cnt++;
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        cpuAddr  = 16'h4014;
        cpuData  = 8'h55;
        cpuWrite = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if ({cpuHalt, busOwn, busAddr, busWrite, busDataOut, done} !== 28'h0)
            $display("FAIL reset_outputs: got %h want 0", {cpuHalt, busOwn, busAddr, busWrite, busDataOut, done});
        else
            pass_cnt++;
        cpuWrite = 1'b0;
        reset_n  = 1'b1;
        repeat (2) begin
            @(negedge clock);
            total_cnt++;
            if ({cpuHalt, busOwn, busAddr, busWrite, busDataOut, done} !== 28'h0)
                $display("FAIL post_reset_idle: got %h want 0", {cpuHalt, busOwn, busAddr, busWrite, busDataOut, done});
            else
                pass_cnt++;
        end
    endtask

    task automatic test_non_trigger();
        logic [15:0] addrs [2] = '{16'h4015, 16'h4014};
        logic        wrs   [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            cpuAddr  = addrs[t];
            cpuData  = 8'($urandom);
            cpuWrite = wrs[t];
            @(negedge clock);
            cpuWrite = 1'b0;
            for (int m = 0; m < 4; m++) begin
                @(negedge clock);
                total_cnt++;
                if ({cpuHalt, busOwn} !== 2'b00)
                    $display("FAIL non_trigger addr=%h wr=%0d: got halt/own=%b want 00", addrs[t], wrs[t], {cpuHalt, busOwn});
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_even_align();
        align_to(0);
        run_xfer(8'h02, -1, -1);
    endtask

    task automatic test_odd_align();
        align_to(1);
        run_xfer(8'h02, -1, -1);
    endtask

    task automatic test_last_page();
        align_to(int'($urandom_range(0, 1)));
        run_xfer(8'hFF, -1, -1);
    endtask

    task automatic test_abort();
        run_xfer(8'h02, -1, 8'h80);
        run_xfer(8'h03, -1, -1);
    endtask

    task automatic test_retrigger();
        run_xfer(8'($urandom_range(4, 254)), int'($urandom_range(0, 254)), -1);
    endtask

    task automatic test_back_to_back();
        run_xfer(8'($urandom), -1, -1);
        run_xfer(8'($urandom), -1, -1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_non_trigger();
        test_even_align();
        test_odd_align();
        test_last_page();
        test_abort();
        test_retrigger();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
